// File: rtl/param_mem_pkg.sv
// Shared definitions for the param_mem_arbiter slice.
//   state_t      : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   *_D          : default datapath geometry
//   clog2()      : ceiling log2, usable in constant expressions
package param_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DATA_WIDTH_D = 16;
  localparam int ADDR_WIDTH_D = 12;
  localparam int DEPTH_D      = 512;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_mem_arbiter_if.sv
// Bundle of the requester-side handshake and the shared-datapath bus.
//   req_valid/req_addr/req_data -> req_ready : request handshake (flattened slices)
//   rsp_valid/rsp_data/rsp_err               : one-cycle response strobe
//   mem_valid/mem_addr/mem_data_in           : command to the shared datapath
//   mem_data_out/mem_ready                   : datapath result
//   busy                                     : sequencer not idle
// Modport slave is the arbiter; modport master is its environment
// (requesters plus the shared datapath).
interface param_mem_arbiter_if
  import param_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          mem_valid;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_data_in;
  logic [DATA_WIDTH-1:0]         mem_data_out;
  logic                          mem_ready;
  logic                          busy;

  modport slave (
    input  req_valid, req_addr, req_data, mem_data_out, mem_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           mem_valid, mem_addr, mem_data_in, busy
  );

  modport master (
    output req_valid, req_addr, req_data, mem_data_out, mem_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           mem_valid, mem_addr, mem_data_in, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant.
//   req    : request vector
//   ptr    : index holding highest priority; priority descends with wrap
//   enable : when low, grant is all zero
//   grant  : one-hot (or zero) grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory-style datapath among
// NUM_REQ requesters, one transaction at a time.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : param_mem_arbiter_if.slave (request handshake, response
//                strobe, datapath command/result, busy)
module param_mem_arbiter
  import param_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DEPTH      = DEPTH_D,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 255
) (
  input logic                clk,
  input logic                reset,
  param_mem_arbiter_if.slave bus
);

  localparam int OWN_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [OWN_W-1:0]      ptr_q, owner_q, grant_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, rsp_data_q;
  logic                  rsp_err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_REQ-1:0]    grant, rsp_valid_c;
  logic                  addr_oor, cnt_last, mem_valid_c, arb_en;

  // Arbitration is only live in IDLE and is masked while reset is held so
  // req_ready reads zero during reset even with requests pending.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(OWN_W)) u_rr (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .enable (arb_en),
    .grant  (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) grant_idx = OWN_W'(i);
  end

  // Range check is made on the latched address during ISSUE, so a bad
  // address responds two cycles after accept without a datapath strobe.
  assign addr_oor = 32'(addr_q) >= DEPTH;
  // Last WAIT cycle: the increment about to happen would reach TIMEOUT.
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_c = 1'b0;
    rsp_valid_c = '0;
    unique case (state_q)
      IDLE:  if (|grant) state_d = ISSUE;
      ISSUE: begin
        mem_valid_c = !addr_oor;
        state_d     = addr_oor ? RESP : WAIT;
      end
      WAIT:  if (bus.mem_ready || cnt_last) state_d = RESP;
      RESP: begin
        rsp_valid_c = NUM_REQ'(1) << owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (|grant) begin
          owner_q <= grant_idx;
          addr_q  <= bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          data_q  <= bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          ptr_q   <= (grant_idx == OWN_W'(NUM_REQ - 1)) ? '0
                                                        : grant_idx + OWN_W'(1);
        end
        ISSUE: begin
          cnt_q <= '0;
          if (addr_oor) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        WAIT: begin
          // Ready takes precedence over a coinciding timeout.
          if (bus.mem_ready) begin
            rsp_data_q <= bus.mem_data_out;
            rsp_err_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_last) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.mem_valid   = mem_valid_c;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = data_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_param_mem_arbiter.sv
// Directed bench for param_mem_arbiter (NUM_REQ=4, DEPTH=512, TIMEOUT=8).
// Inputs change and outputs are sampled at the falling edge; the DUT acts
// on the rising edge.
module tb_param_mem_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_mem_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  param_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(512), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Accept a single request from requester who and move into ISSUE.
  task automatic accept(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input string tag);
    logic [NR-1:0] one;
    one = '0;
    one[who] = 1'b1;
    set_req(who, a, d);
    bus.req_valid = one;
    #1;
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(one));
    step();
    bus.req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] eg;
    reset            = 1'b1;
    bus.req_valid    = '0;
    bus.req_addr     = '0;
    bus.req_data     = '0;
    bus.mem_data_out = '0;
    bus.mem_ready    = 1'b0;
    step(); step();
    chk("rst_busy",   32'(bus.busy),        0);
    chk("rst_mvalid", 32'(bus.mem_valid),   0);
    chk("rst_maddr",  32'(bus.mem_addr),    0);
    chk("rst_mdin",   32'(bus.mem_data_in), 0);
    chk("rst_rvalid", 32'(bus.rsp_valid),   0);
    chk("rst_rdata",  32'(bus.rsp_data),    0);
    chk("rst_rerr",   32'(bus.rsp_err),     0);
    reset = 1'b0;

    // Single request from requester 0, ready one cycle after mem_valid.
    accept(0, 12'h010, 16'hBEEF, "single");
    chk("single_mvalid", 32'(bus.mem_valid),   1);
    chk("single_maddr",  32'(bus.mem_addr),    32'h010);
    chk("single_mdin",   32'(bus.mem_data_in), 32'hBEEF);
    chk("single_rdy0",   32'(bus.req_ready),   0);
    step();
    chk("single_wait_mv", 32'(bus.mem_valid), 0);
    bus.mem_ready = 1'b1; bus.mem_data_out = 16'h1234;
    step();
    bus.mem_ready = 1'b0; bus.mem_data_out = 16'h0000;
    chk("single_rvalid", 32'(bus.rsp_valid), 32'b0001);
    chk("single_rdata",  32'(bus.rsp_data),  32'h1234);
    chk("single_rerr",   32'(bus.rsp_err),   0);
    chk("single_rsprdy", 32'(bus.req_ready), 0);
    step();
    chk("single_idle",  32'(bus.busy),      0);
    chk("single_hold",  32'(bus.rsp_data),  32'h1234);
    chk("single_rv0",   32'(bus.rsp_valid), 0);

    // mem_ready in IDLE must not start anything.
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("stray_ready_busy", 32'(bus.busy), 0);

    // Out-of-range address from requester 2 (pointer now at 1).
    accept(2, 12'h200, 16'h7777, "oor");
    chk("oor_mvalid", 32'(bus.mem_valid), 0);
    step();
    chk("oor_rvalid", 32'(bus.rsp_valid), 32'b0100);
    chk("oor_rerr",   32'(bus.rsp_err),   1);
    chk("oor_rdata",  32'(bus.rsp_data),  0);
    step();
    chk("oor_idle", 32'(bus.busy), 0);

    // Timeout on requester 3: eight WAIT cycles, no ready.
    accept(3, 12'h020, 16'h0101, "to");
    chk("to_mvalid", 32'(bus.mem_valid), 1);
    for (int w = 0; w < TO; w++) begin
      step();
      chk("to_wait_rv", 32'(bus.rsp_valid), 0);
    end
    step();
    chk("to_rvalid", 32'(bus.rsp_valid), 32'b1000);
    chk("to_rerr",   32'(bus.rsp_err),   1);
    chk("to_rdata",  32'(bus.rsp_data),  0);
    step();
    chk("to_idle", 32'(bus.busy), 0);

    // Ready on the timeout cycle wins; addr DEPTH-1 is in range.
    accept(1, 12'h1FF, 16'h5555, "col");
    chk("col_mvalid", 32'(bus.mem_valid), 1);
    chk("col_maddr",  32'(bus.mem_addr),  32'h1FF);
    for (int w = 0; w < TO; w++) begin
      step();
      if (w == TO - 1) begin
        bus.mem_ready = 1'b1; bus.mem_data_out = 16'hCAFE;
      end
    end
    step();
    bus.mem_ready = 1'b0;
    chk("col_rvalid", 32'(bus.rsp_valid), 32'b0010);
    chk("col_rerr",   32'(bus.rsp_err),   0);
    chk("col_rdata",  32'(bus.rsp_data),  32'hCAFE);
    step();

    // Reset asserted asynchronously in WAIT with all requests pending.
    accept(2, 12'h030, 16'h3333, "mid");
    step();
    bus.req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    chk("mid_busy",   32'(bus.busy),        0);
    chk("mid_mvalid", 32'(bus.mem_valid),   0);
    chk("mid_maddr",  32'(bus.mem_addr),    0);
    chk("mid_mdin",   32'(bus.mem_data_in), 0);
    chk("mid_rdata",  32'(bus.rsp_data),    0);
    chk("mid_rerr",   32'(bus.rsp_err),     0);
    chk("mid_rdy",    32'(bus.req_ready),   0);
    step();
    bus.req_valid = '0;
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      step();
      chk("mid_norsp", 32'(bus.rsp_valid | {3'b000, bus.busy}), 0);
    end

    // Round-robin with all four held high: 0,1,2,3,0, one grant per 4 cycles.
    for (int i = 0; i < NR; i++) set_req(i, AW'(12'h100 + i), DW'(16'hA000 + i));
    bus.req_valid = 4'b1111;
    for (int k = 0; k <= NR; k++) begin
      eg = 4'b0001 << (k % NR);
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(eg));
      step();
      chk("rr_maddr", 32'(bus.mem_addr), 32'h100 + (k % NR));
      step();
      bus.mem_ready = 1'b1; bus.mem_data_out = DW'(16'h2000 + k);
      step();
      bus.mem_ready = 1'b0;
      chk("rr_rvalid", 32'(bus.rsp_valid), 32'(eg));
      chk("rr_rdata",  32'(bus.rsp_data),  32'h2000 + k);
      step();
    end
    bus.req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
